float_to_fixed_sp: RTL and testbench

FLOAT_TO_FIXED_SP -- requirements
Module: float_to_fixed_sp

---
 rtl/float_to_fixed_sp.sv | 170 +++++++++++++++++
 tb/tb_float_to_fixed_sp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_sp.sv
// -----------------------------------------------------------------------------
// float_to_fixed_sp
//   Converts IEEE-754 single-precision words to signed fixed point
//   Q(p).(31-p), p = p_INTEGER_BIT_COUNT. Three-stage pipeline with a
//   valid/ready handshake on both sides; the whole pipeline advances together
//   whenever the output register can accept a new entry.
//
//   S1 unpack/classify : sign, significand {1,mant}, alignment shift k, class
//   S2 align-shift     : magnitude = sig << k or sig >> -k (truncating)
//   S3 negate/saturate : two's complement, clamp, flags -> output register
//
// Ports
//   i_CLK          clock, rising edge
//   i_RST          synchronous active-high reset
//   i_VALID        i_FLOAT_WORD carries a word this cycle
//   i_FLOAT_WORD   {sign, exp[7:0], mant[22:0]}
//   o_READY        input accepted this cycle when i_VALID is also high
//   o_VALID        o_FIXED_WORD / flags are valid
//   i_READY        downstream takes the output this cycle
//   o_FIXED_WORD   signed fixed-point result
//   o_OVERFLOW     result was saturated
//   o_INVALID      input was NaN
// -----------------------------------------------------------------------------
module float_to_fixed_sp #(
    parameter int p_INTEGER_BIT_COUNT = 31
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_VALID,
    input  logic [31:0]        i_FLOAT_WORD,
    output logic               o_READY,
    output logic               o_VALID,
    input  logic               i_READY,
    output logic signed [31:0] o_FIXED_WORD,
    output logic               o_OVERFLOW,
    output logic               o_INVALID
);

    typedef enum logic [1:0] {
        CLS_ZERO,   // zero, denormal, or below one LSB
        CLS_NORM,   // finite value that needs shifting
        CLS_INF,
        CLS_NAN
    } class_t;

    typedef struct packed {
        logic               sign;
        class_t             cls;
        logic [23:0]        sig;
        logic signed [9:0]  k;
    } s1_t;

    typedef struct packed {
        logic               sign;
        class_t             cls;
        logic               big;    // k > 8: magnitude certainly >= 2^31
        logic [31:0]        mag;
    } s2_t;

    // Shift that maps the unbiased significand LSB onto the output LSB.
    localparam logic signed [9:0] K_BIAS = 10'(119 + p_INTEGER_BIT_COUNT);

    logic              s1_valid, s2_valid;
    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [7:0]        in_exp;
    logic signed [9:0] in_k;
    logic [3:0]        s2_lsh;
    logic [4:0]        s2_rsh;
    logic [31:0]       s3_word_d;
    logic              s3_ovf_d, s3_inv_d;
    logic [31:0]       sat_word;

    // Pipeline moves whenever the output slot is empty or being drained.
    assign o_READY = !o_VALID || i_READY;

    // ---------------- S1: unpack / classify ----------------
    assign in_exp = i_FLOAT_WORD[30:23];
    assign in_k   = $signed({2'b00, in_exp}) - K_BIAS;

    always_comb begin
        // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
        s1_d      = '0;
        s1_d.sign = i_FLOAT_WORD[31];
        s1_d.sig  = {1'b1, i_FLOAT_WORD[22:0]};
        s1_d.k    = in_k;
        if (in_exp == 8'hFF)
            s1_d.cls = (i_FLOAT_WORD[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (in_exp == 8'h00 || in_k < -10'sd23)
            s1_d.cls = CLS_ZERO;
        else
            s1_d.cls = CLS_NORM;
    end

    // ---------------- S2: align shift ----------------
    // Left shifts beyond 8 are flagged as big, so only 4 bits of k matter;
    // right shifts are at most 23 for anything still classed CLS_NORM.
    assign s2_lsh = 4'(s1_q.k);
    assign s2_rsh = 5'(-s1_q.k);

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.cls  = s1_q.cls;
        s2_d.big  = s1_q.k > 10'sd8;
        if (s1_q.k >= 10'sd0)
            s2_d.mag = {8'd0, s1_q.sig} << s2_lsh;
        else
            s2_d.mag = {8'd0, s1_q.sig} >> s2_rsh;
    end

    // ---------------- S3: negate / saturate ----------------
    assign sat_word = s2_q.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

    always_comb begin
        s3_word_d = '0;
        s3_ovf_d  = 1'b0;
        s3_inv_d  = 1'b0;
        // Bubbles load zeros so the flags can never be high without o_VALID.
        if (s2_valid) begin
            unique case (s2_q.cls)
                CLS_NAN: s3_inv_d = 1'b1;
                CLS_INF: begin
                    s3_word_d = sat_word;
                    s3_ovf_d  = 1'b1;
                end
                CLS_NORM: begin
                    // -2^31 is the one magnitude with bit 31 set that still fits.
                    if (s2_q.big ||
                        (s2_q.mag[31] && !(s2_q.sign && s2_q.mag == 32'h8000_0000))) begin
                        s3_word_d = sat_word;
                        s3_ovf_d  = 1'b1;
                    end else begin
                        s3_word_d = s2_q.sign ? -s2_q.mag : s2_q.mag;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- control / output registers ----------------
    always_ff @(posedge i_CLK) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
        if (i_RST) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            o_VALID      <= 1'b0;
            o_FIXED_WORD <= '0;
            o_OVERFLOW   <= 1'b0;
            o_INVALID    <= 1'b0;
        end else if (o_READY) begin
            s1_valid     <= i_VALID;
            s2_valid     <= s1_valid;
            o_VALID      <= s2_valid;
            o_FIXED_WORD <= s3_word_d;
            o_OVERFLOW   <= s3_ovf_d;
            o_INVALID    <= s3_inv_d;
        end
    end

    // NOTE: payload registers are not reset; their contents are ignored until the matching valid bit is set.
    always_ff @(posedge i_CLK) begin
        if (o_READY) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// -----------------------------------------------------------------------------
// tb_float_to_fixed_sp
//   Two instances: dut31 (p=31) carries the main, backpressure and reset
//   sequences; dut15 (p=15) carries the Q15.16 vectors. Expected results come
//   from a real-arithmetic model of the float value scaled to output LSBs; each
//   directed vector also pins that model against a hand-computed literal.
// -----------------------------------------------------------------------------
module tb_float_to_fixed_sp;

    typedef struct {
        logic [31:0] w;
        logic        ovf;
        logic        inv;
        int          cyc;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v31 = 1'b0, v15 = 1'b0;
    logic [31:0] f31 = '0, f15 = '0;
    logic        r31 = 1'b1, r15 = 1'b1;
    logic        rdy31, rdy15, ov31, ov15;
    logic [31:0] w31, w15;
    logic        ovf31, ovf15, inv31, inv15;

    int     total = 0, bad = 0;
    int     cyc = 0;
    int     delivered31 = 0;
    logic   strict_lat = 1'b1;
    model_t q31[$], q15[$];

    logic        prev_stall = 1'b0, prev_rst = 1'b1;
    logic [33:0] prev_out = '0;

    float_to_fixed_sp #(.p_INTEGER_BIT_COUNT(31)) dut31 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(v31), .i_FLOAT_WORD(f31),
        .o_READY(rdy31), .o_VALID(ov31), .i_READY(r31),
        .o_FIXED_WORD(w31), .o_OVERFLOW(ovf31), .o_INVALID(inv31)
    );

    float_to_fixed_sp #(.p_INTEGER_BIT_COUNT(15)) dut15 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(v15), .i_FLOAT_WORD(f15),
        .o_READY(rdy15), .o_VALID(ov15), .i_READY(r15),
        .o_FIXED_WORD(w15), .o_OVERFLOW(ovf15), .o_INVALID(inv15)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Value of the float in output LSBs, truncated toward zero, clamped to int32.
    function automatic model_t model(input logic [31:0] w, input int p, input int at);
        model_t r;
        real    mag;
        real    lim;
        int     e;
        int     t;
        r.w = '0; r.ovf = 1'b0; r.inv = 1'b0; r.cyc = at;
        lim = 2147483648.0;
        e   = int'(w[30:23]);
        if (e == 255) begin
            if (w[22:0] != 23'd0) r.inv = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.w   = w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (e != 0) begin
            mag = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** real'(e - 127))
                  * (2.0 ** real'(31 - p));
            if (w[31] && mag == lim) r.w = 32'h8000_0000;
            else if (mag >= lim) begin
                r.ovf = 1'b1;
                r.w   = w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                t   = $rtoi(mag);
                r.w = w[31] ? 32'(-t) : 32'(t);
            end
        end
        return r;
    endfunction

    // ---------------- dut31 monitor / scoreboard ----------------
    always @(negedge clk) begin
        model_t e;
        check("ready31_rule", rdy31, !ov31 || r31);
        if (!ov31) check("idle31_flags", {ovf31, inv31}, 2'b00);
        if (prev_stall && !prev_rst) begin
            check("hold31_valid", ov31, 1'b1);
            check("hold31_out", {w31, ovf31, inv31}, prev_out);
        end
        if (rst) begin
            q31.delete();
        end else begin
            if (ov31 && r31) begin
                check("out31_expected", q31.size() != 0, 1'b1);
                if (q31.size() != 0) begin
                    e = q31.pop_front();
                    check("out31_word", w31, e.w);
                    check("out31_flags", {ovf31, inv31}, {e.ovf, e.inv});
                    if (strict_lat) check("out31_latency", cyc - e.cyc, 3);
                end
                delivered31++;
            end
            if (v31 && rdy31) q31.push_back(model(f31, 31, cyc));
        end
        prev_stall = ov31 && !r31;
        prev_out   = {w31, ovf31, inv31};
        prev_rst   = rst;
    end

    // ---------------- dut15 monitor / scoreboard ----------------
    always @(negedge clk) begin
        model_t e;
        if (rst) begin
            q15.delete();
        end else begin
            if (ov15 && r15) begin
                check("out15_expected", q15.size() != 0, 1'b1);
                if (q15.size() != 0) begin
                    e = q15.pop_front();
                    check("out15_word", w15, e.w);
                    check("out15_flags", {ovf15, inv15}, {e.ovf, e.inv});
                    check("out15_latency", cyc - e.cyc, 3);
                end
            end
            if (v15 && rdy15) q15.push_back(model(f15, 15, cyc));
        end
    end

    // Present a word at posedge+2 and hold it until the edge that accepts it.
    // The literal pins the model for this vector.
    task automatic send(input int p, input logic [31:0] w,
                        input logic [31:0] lit_w, input logic lit_ovf, input logic lit_inv);
        model_t m;
        int     guard;
        logic   acc;
        m = model(w, p, 0);
        check($sformatf("model_pin_%0h_p%0d", w, p), {m.w, m.ovf, m.inv}, {lit_w, lit_ovf, lit_inv});
        if (p == 31) begin v31 = 1'b1; f31 = w; end
        else         begin v15 = 1'b1; f15 = w; end
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 50) begin
            acc = (p == 31) ? rdy31 : rdy15;
            @(posedge clk); #2;
            guard++;
        end
        if (!acc) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle();
        v31 = 1'b0;
        v15 = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q31.size() != 0 || q15.size() != 0) && guard < 60) begin
            @(posedge clk); #2;
            guard++;
        end
        check("drain31_empty", q31.size(), 0);
        check("drain15_empty", q15.size(), 0);
    endtask

    initial begin
        int base;
        int guard;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_valid31", ov31, 1'b0);
        check("rst_out31", {w31, ovf31, inv31}, 34'd0);
        check("rst_ready31", rdy31, 1'b1);
        check("rst_valid15", ov15, 1'b0);
        check("rst_ready15", rdy15, 1'b1);

        // ---- basic stream, back-to-back, p=31 ----
        send(31, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0);
        send(31, 32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b0);
        send(31, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0);
        // ---- boundaries ----
        send(31, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send(31, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(31, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0);
        // ---- specials ----
        send(31, 32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1);
        send(31, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
        send(31, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send(31, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        send(31, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        send(31, 32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0);
        idle();

        // ---- p=15 ----
        send(15, 32'h3FC0_0000, 32'h0001_8000, 1'b0, 1'b0);
        send(15, 32'hBE80_0000, 32'hFFFF_C000, 1'b0, 1'b0);
        send(15, 32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send(15, 32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(15, 32'h3780_0000, 32'h0000_0001, 1'b0, 1'b0);
        idle();
        drain();

        // ---- backpressure: 6 words, output stalled 5 cycles ----
        strict_lat = 1'b0;
        base = delivered31;
        #0 r31 = 1'b0;
        fork
            begin
                send(31, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0);
                send(31, 32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0);
                send(31, 32'h4040_0000, 32'h0000_0003, 1'b0, 1'b0);
                send(31, 32'hC080_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
                send(31, 32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1);
                send(31, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
                idle();
            end
            begin
                guard = 0;
                while (!ov31 && guard < 20) begin
                    @(posedge clk); #1;
                    guard++;
                end
                check("bp_valid_seen", ov31, 1'b1);
                check("bp_ready_low", rdy31, 1'b0);
                repeat (5) @(posedge clk);
                #1 r31 = 1'b1;
            end
        join
        drain();
        repeat (3) @(posedge clk);
        #2 check("bp_delivered", delivered31 - base, 6);

        // ---- reset with 3 words in flight and output stalled ----
        #0 r31 = 1'b0;
        send(31, 32'h4080_0000, 32'h0000_0004, 1'b0, 1'b0);
        send(31, 32'h40A0_0000, 32'h0000_0005, 1'b0, 1'b0);
        send(31, 32'h40C0_0000, 32'h0000_0006, 1'b0, 1'b0);
        idle();
        check("pre_rst_stalled", {ov31, rdy31}, 2'b10);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("post_rst_valid", ov31, 1'b0);
        check("post_rst_out", {w31, ovf31, inv31}, 34'd0);
        check("post_rst_ready", rdy31, 1'b1);
        base = delivered31;
        r31 = 1'b1;
        strict_lat = 1'b1;
        send(31, 32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0);
        idle();
        repeat (10) @(posedge clk);
        #2 check("post_rst_delivered", delivered31 - base, 1);
        check("post_rst_queue", q31.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
